// File: rtl/doodle_physics_if.sv
// Doodle physics bus: SM/video-side controls in, doodle position and events out.
// Signals:
//   frame_tick            one-cycle pulse per video frame
//   btn_left, btn_right   horizontal move buttons (level)
//   q_I, q_Up, q_Down     doodle state machine state flags
//   object_x, object_y    doodle top-left position
//   scroll                playfield scroll, 0..V_RES-1
//   landed, hit_idx       landing pulse and index of the platform landed on
//   fell                  pulse when the doodle bottom reaches the screen bottom
//   busy                  frame update in progress
// master: the side that drives controls (state machine / bench).
// slave:  the physics engine.
interface doodle_physics_if;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       q_I;
    logic       q_Up;
    logic       q_Down;
    logic [9:0] object_x;
    logic [9:0] object_y;
    logic [9:0] scroll;
    logic       landed;
    logic [2:0] hit_idx;
    logic       fell;
    logic       busy;

    modport master (
        output frame_tick, btn_left, btn_right, q_I, q_Up, q_Down,
        input  object_x, object_y, scroll, landed, hit_idx, fell, busy
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, q_I, q_Up, q_Down,
        output object_x, object_y, scroll, landed, hit_idx, fell, busy
    );
endinterface

// File: rtl/doodle_physics.sv
// Per-frame motion and collision engine for the doodle game.
// Each accepted frame_tick moves the doodle one step (buttons + SM state),
// scrolls the playfield while rising above mid-screen, and, while falling,
// scans a fixed six-entry platform table for a landing.
// Ports:
//   Clk    system clock
//   Reset  asynchronous, active-high reset
//   bus    doodle_physics_if.slave (controls in; position, scroll, events out)
// Build option:
//   DOODLE_WRAP_EN  defined: doodle wraps around the left/right screen edges;
//                   undefined: doodle is clamped to [0, H_RES-DOODLE_W].
module doodle_physics (
    input  logic             Clk,
    input  logic             Reset,
    doodle_physics_if.slave  bus
);

    localparam int unsigned H_RES    = 640;
    localparam int unsigned V_RES    = 480;
    localparam int unsigned V_MIDDLE = 240;
    localparam int unsigned DOODLE_W = 32;
    localparam int unsigned DOODLE_H = 32;
    localparam int unsigned PLAT_W   = 64;
    localparam int unsigned H_STEP   = 4;
    localparam int unsigned V_STEP   = 4;
    localparam int unsigned X_START  = 304;
    localparam int unsigned Y_START  = 420;
    localparam int unsigned POS_W    = 10;
    localparam int unsigned EXT_W    = 11;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned NUM_PLAT = 6;

    // 11-bit working copies so all position arithmetic has headroom
    localparam logic [EXT_W-1:0] C_H_RES    = EXT_W'(H_RES);
    localparam logic [EXT_W-1:0] C_V_RES    = EXT_W'(V_RES);
    localparam logic [EXT_W-1:0] C_V_MIDDLE = EXT_W'(V_MIDDLE);
    localparam logic [EXT_W-1:0] C_DOODLE_W = EXT_W'(DOODLE_W);
    localparam logic [EXT_W-1:0] C_DOODLE_H = EXT_W'(DOODLE_H);
    localparam logic [EXT_W-1:0] C_PLAT_W   = EXT_W'(PLAT_W);
    localparam logic [EXT_W-1:0] C_H_STEP   = EXT_W'(H_STEP);
    localparam logic [EXT_W-1:0] C_V_STEP   = EXT_W'(V_STEP);
    localparam logic [POS_W-1:0] C_X_START  = POS_W'(X_START);
    localparam logic [POS_W-1:0] C_Y_START  = POS_W'(Y_START);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_PLAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [POS_W-1:0] x_q;
    logic [POS_W-1:0] y_q;
    logic [POS_W-1:0] scroll_q;
    logic [IDX_W-1:0] hit_q;
    logic             landed_q;
    logic             fell_q;
    logic             busy_q;

    logic [EXT_W-1:0] x_ext;
    logic [EXT_W-1:0] y_ext;
    logic [EXT_W-1:0] scroll_ext;

    assign x_ext      = {1'b0, x_q};
    assign y_ext      = {1'b0, y_q};
    assign scroll_ext = {1'b0, scroll_q};

    // Horizontal step with edge handling (wrap or clamp)
    logic             move_left_c;
    logic             move_right_c;
    logic [POS_W-1:0] x_nx;

    assign move_left_c  = bus.btn_left & ~bus.btn_right;
    assign move_right_c = bus.btn_right & ~bus.btn_left;

    always_comb begin
        x_nx = x_q;
        if (move_left_c) begin
            if (x_ext < C_H_STEP) begin
`ifdef DOODLE_WRAP_EN
                x_nx = POS_W'(C_H_RES - C_DOODLE_W);
`else
                x_nx = '0;
`endif
            end else begin
                x_nx = POS_W'(x_ext - C_H_STEP);
            end
        end else if (move_right_c) begin
            if (x_ext + C_DOODLE_W + C_H_STEP > C_H_RES) begin
`ifdef DOODLE_WRAP_EN
                x_nx = '0;
`else
                x_nx = POS_W'(C_H_RES - C_DOODLE_W);
`endif
            end else begin
                x_nx = POS_W'(x_ext + C_H_STEP);
            end
        end
    end

    // Vertical step: rising above mid-screen scrolls the field instead of moving
    logic             falling_c;
    logic             fell_c;
    logic [EXT_W-1:0] y_sum;
    logic [EXT_W-1:0] scroll_sum;
    logic [POS_W-1:0] y_nx;
    logic [POS_W-1:0] scroll_nx;

    assign falling_c = bus.q_Down & ~bus.q_Up;

    always_comb begin
        y_nx       = y_q;
        scroll_nx  = scroll_q;
        fell_c     = 1'b0;
        y_sum      = '0;
        scroll_sum = '0;
        if (bus.q_Up) begin
            if (y_ext > C_V_MIDDLE) begin
                y_nx = POS_W'(y_ext - C_V_STEP);
            end else begin
                scroll_sum = scroll_ext + C_V_STEP;
                scroll_nx  = (scroll_sum >= C_V_RES) ? POS_W'(scroll_sum - C_V_RES)
                                                     : POS_W'(scroll_sum);
            end
        end else if (bus.q_Down) begin
            y_sum = y_ext + C_V_STEP;
            if (y_sum + C_DOODLE_H >= C_V_RES) begin
                fell_c = 1'b1;
                y_nx   = POS_W'(C_V_RES - C_DOODLE_H);
            end else begin
                y_nx = POS_W'(y_sum);
            end
        end
    end

    // Platform table lookup and landing test for the entry under scan
    logic [EXT_W-1:0] tbl_x;
    logic [EXT_W-1:0] tbl_y;
    logic [EXT_W-1:0] py_sum;
    logic [EXT_W-1:0] py;
    logic [EXT_W-1:0] bottom;
    logic             hit_c;
    logic [POS_W-1:0] land_y;

    always_comb begin
        tbl_x = '0;
        tbl_y = '0;
        case (idx)
            3'd0:    begin tbl_x = 11'd374; tbl_y = 11'd448; end
            3'd1:    begin tbl_x = 11'd256; tbl_y = 11'd400; end
            3'd2:    begin tbl_x = 11'd560; tbl_y = 11'd322; end
            3'd3:    begin tbl_x = 11'd300; tbl_y = 11'd292; end
            3'd4:    begin tbl_x = 11'd200; tbl_y = 11'd192; end
            3'd5:    begin tbl_x = 11'd400; tbl_y = 11'd137; end
            default: begin tbl_x = '0;      tbl_y = '0;      end
        endcase
    end

    always_comb begin
        py_sum = tbl_y + scroll_ext;
        py     = (py_sum >= C_V_RES) ? (py_sum - C_V_RES) : py_sum;
        bottom = y_ext + C_DOODLE_H;
        // Landing window is one vertical step deep so a fall never skips a platform
        hit_c  = (py <= bottom) && (bottom < py + C_V_STEP) &&
                 (x_ext + C_DOODLE_W > tbl_x) && (x_ext < tbl_x + C_PLAT_W);
        land_y = POS_W'(py - C_DOODLE_H);
    end

    // Frame sequencer with registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            x_q      <= C_X_START;
            y_q      <= C_Y_START;
            scroll_q <= '0;
            hit_q    <= '0;
            landed_q <= 1'b0;
            fell_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            landed_q <= 1'b0;
            fell_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.frame_tick) begin
                        if (bus.q_I) begin
                            x_q      <= C_X_START;
                            y_q      <= C_Y_START;
                            scroll_q <= '0;
                        end else begin
                            state  <= S_MOVE;
                            busy_q <= 1'b1;
                        end
                    end
                end
                S_MOVE: begin
                    x_q      <= x_nx;
                    y_q      <= y_nx;
                    scroll_q <= scroll_nx;
                    if (fell_c) begin
                        fell_q <= 1'b1;
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else if (falling_c) begin
                        idx   <= '0;
                        state <= S_SCAN;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (hit_c) begin
                        y_q      <= land_y;
                        hit_q    <= idx;
                        landed_q <= 1'b1;
                        state    <= S_IDLE;
                        busy_q   <= 1'b0;
                    end else if (idx == C_LAST_IDX) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.object_x = x_q;
    assign bus.object_y = y_q;
    assign bus.scroll   = scroll_q;
    assign bus.landed   = landed_q;
    assign bus.hit_idx  = hit_q;
    assign bus.fell     = fell_q;
    assign bus.busy     = busy_q;

endmodule
